// File: rtl/mrd_pkg.sv
// Shared types and constants for the radix-5 pass sequencer and its helpers.
package mrd_pkg;

    localparam int SMP_W             = 18;
    localparam int RDX5_WORST_GROWTH = 3;
    // A pass can grow by at most RDX5_WORST_GROWTH bits, so headroom beyond that is never needed.
    localparam logic [1:0] MARGIN_MAX = 2'(RDX5_WORST_GROWTH);

    typedef logic signed [SMP_W-1:0] smp_t;
    typedef smp_t [4:0] rdx5_vec_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fsm_e;

endpackage

// File: rtl/mrd_headroom10.sv
// Minimum headroom over the 10 real/imag samples of one radix-5 butterfly output.
module mrd_headroom10
    import mrd_pkg::*;
(
    input  rdx5_vec_t  re_i,
    input  rdx5_vec_t  im_i,
    output logic [1:0] margin_o
);

    localparam smp_t LIM1 = 18'sd65536;
    localparam smp_t LIM2 = 18'sd32768;
    localparam smp_t LIM3 = 18'sd16384;

    // A sample with h redundant sign bits fits in the signed range of an (18-h)-bit word.
    function automatic logic [1:0] smp_headroom(input smp_t s);
        logic [1:0] h;
        if (s >= -LIM3 && s < LIM3)      h = 2'd3;
        else if (s >= -LIM2 && s < LIM2) h = 2'd2;
        else if (s >= -LIM1 && s < LIM1) h = 2'd1;
        else                             h = 2'd0;
        return h;
    endfunction

    always_comb begin
        margin_o = MARGIN_MAX;
        for (int i = 0; i < 5; i++) begin
            if (smp_headroom(re_i[i]) < margin_o) margin_o = smp_headroom(re_i[i]);
            if (smp_headroom(im_i[i]) < margin_o) margin_o = smp_headroom(im_i[i]);
        end
    end

endmodule

// File: rtl/mrd_rdx5_sched.sv
// Radix-5 pass sequencer: credit-paced butterfly issue, drain tracking and
// block-floating-point margin/exponent reporting for the next pass.
module mrd_rdx5_sched
    import mrd_pkg::*;
#(
    parameter int IDX_W    = 12,
    parameter int RD_LAT   = 2,
    parameter int CORE_LAT = 3,
    parameter int CREDITS  = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] n_bfly,
    input  logic [3:0]       exp_in,
    input  logic [1:0]       margin_in,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_idx,
    output logic             core_in_val,
    output logic [1:0]       core_margin,
    output logic [3:0]       core_exp,
    input  logic             core_out_val,
    input  rdx5_vec_t        core_dout_real,
    input  rdx5_vec_t        core_dout_imag,
    input  logic [3:0]       core_exp_out,
    input  logic             cred_ret,
    output logic             busy,
    output logic             done,
    output logic [3:0]       exp_out,
    output logic [1:0]       margin_out
);

    localparam int CRED_W = $clog2(CREDITS + 1);
    // Early credit returns can let in-flight exceed CREDITS, but never the issue-to-output latency.
    localparam int INFL_W = $clog2(CREDITS + RD_LAT + CORE_LAT + 2);

    fsm_e               state_q;
    logic [IDX_W-1:0]   n_q, k_q, rd_idx_q;
    logic [CRED_W-1:0]  cred_q, cred_d;
    logic [INFL_W-1:0]  infl_q, infl_d;
    logic [RD_LAT-1:0]  sr_q;
    logic [3:0]         exp_lat_q, exp_nxt_q, exp_out_q;
    logic [1:0]         margin_lat_q, acc_q, margin_out_q;
    logic               rd_en_q, busy_q, done_q;
    logic               issue_d;
    logic [1:0]         hr_w;

    mrd_headroom10 u_hr (
        .re_i     (core_dout_real),
        .im_i     (core_dout_imag),
        .margin_o (hr_w)
    );

    always_comb begin
        issue_d = (state_q == ISSUE) && (cred_q != '0);

        cred_d = cred_q;
        if (issue_d && !cred_ret)
            cred_d = cred_q - 1'b1;
        else if (!issue_d && cred_ret && cred_q != CRED_W'(CREDITS))
            cred_d = cred_q + 1'b1;

        infl_d = infl_q;
        if (issue_d && !core_out_val)
            infl_d = infl_q + 1'b1;
        else if (!issue_d && core_out_val && infl_q != '0)
            infl_d = infl_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            k_q          <= '0;
            rd_idx_q     <= '0;
            cred_q       <= CRED_W'(CREDITS);
            infl_q       <= '0;
            sr_q         <= '0;
            exp_lat_q    <= '0;
            exp_nxt_q    <= '0;
            exp_out_q    <= '0;
            margin_lat_q <= '0;
            acc_q        <= MARGIN_MAX;
            margin_out_q <= MARGIN_MAX;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cred_q  <= cred_d;
            infl_q  <= infl_d;
            sr_q    <= RD_LAT'({sr_q, rd_en_q});
            rd_en_q <= issue_d;
            done_q  <= 1'b0;

            if (core_out_val) begin
                acc_q     <= (hr_w < acc_q) ? hr_w : acc_q;
                exp_nxt_q <= core_exp_out;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q          <= n_bfly;
                        k_q          <= '0;
                        exp_lat_q    <= exp_in;
                        margin_lat_q <= margin_in;
                        exp_nxt_q    <= exp_in;
                        acc_q        <= MARGIN_MAX;
                        if (n_bfly == '0) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            exp_out_q    <= exp_in;
                            margin_out_q <= margin_in;
                        end else begin
                            state_q <= ISSUE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_d) begin
                        rd_idx_q <= k_q;
                        k_q      <= k_q + 1'b1;
                        if (k_q == n_q - 1'b1) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (infl_q == '0) begin
                        state_q      <= DONE;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        exp_out_q    <= exp_nxt_q;
                        margin_out_q <= acc_q;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_idx      = rd_idx_q;
    assign core_in_val = sr_q[RD_LAT-1];
    assign core_margin = margin_lat_q;
    assign core_exp    = exp_lat_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign exp_out     = exp_out_q;
    assign margin_out  = margin_out_q;

endmodule

// File: tb/tb_mrd_rdx5_sched.sv
// Bench for mrd_rdx5_sched: behavioural core/buffer model plus directed pass scenarios.
module tb_mrd_rdx5_sched;
    import mrd_pkg::*;

    localparam int IDX_W    = 12;
    localparam int RD_LAT   = 2;
    localparam int CORE_LAT = 3;
    localparam int CREDITS  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W-1:0] n_bfly = '0;
    logic [3:0]       exp_in = '0;
    logic [1:0]       margin_in = '0;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             core_in_val;
    logic [1:0]       core_margin;
    logic [3:0]       core_exp;
    logic             core_out_val = 1'b0;
    rdx5_vec_t        core_dout_real = '0;
    rdx5_vec_t        core_dout_imag = '0;
    logic [3:0]       core_exp_out = '0;
    logic             cred_ret = 1'b0;
    logic             busy;
    logic             done;
    logic [3:0]       exp_out;
    logic [1:0]       margin_out;

    always #5 clk = ~clk;

    mrd_rdx5_sched #(
        .IDX_W(IDX_W), .RD_LAT(RD_LAT), .CORE_LAT(CORE_LAT), .CREDITS(CREDITS)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_bfly(n_bfly),
        .exp_in(exp_in), .margin_in(margin_in), .rd_en(rd_en), .rd_idx(rd_idx),
        .core_in_val(core_in_val), .core_margin(core_margin), .core_exp(core_exp),
        .core_out_val(core_out_val), .core_dout_real(core_dout_real),
        .core_dout_imag(core_dout_imag), .core_exp_out(core_exp_out),
        .cred_ret(cred_ret), .busy(busy), .done(done), .exp_out(exp_out),
        .margin_out(margin_out)
    );

    int checks = 0, errors = 0, cyc = 0;
    bit m_active = 0;
    int m_n, m_exp_in, m_mar_in, m_issued, m_outs, m_min, m_last_exp;
    int m_cred = CREDITS;
    logic rdq [RD_LAT];
    logic ih [CORE_LAT+1];
    int iss_cyc [64];
    int first_in_cyc = -1, done_cnt = 0, last_done_issued = 0;
    int ret_mode = 0, ret_from = 0, spec_idx = -1;
    logic [17:0] spec_val = '0;
    logic [3:0]  cur_exp = '0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Headroom straight from the definition: count leading bits equal to the sign bit.
    function automatic int hr_bits(input logic [17:0] v);
        int h = 0;
        for (int b = 16; b >= 0; b--) begin
            if (v[b] != v[17]) break;
            h++;
        end
        return (h > 3) ? 3 : h;
    endfunction

    task automatic reset_models();
        m_active = 0; m_issued = 0; m_outs = 0; m_min = 3;
        m_cred = CREDITS;
        for (int i = 0; i < RD_LAT; i++) rdq[i] = 1'b0;
        for (int i = 0; i <= CORE_LAT; i++) ih[i] = 1'b0;
        core_out_val = 1'b0;
        cred_ret = 1'b0;
    endtask

    task automatic step();
        logic was_rst;
        rdx5_vec_t re, im;
        was_rst = !rst_n;
        @(posedge clk); #1;
        cyc++;
        if (was_rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_in_val", core_in_val, 0);
            chk("rst_exp_out", exp_out, 0);
            chk("rst_margin_out", margin_out, 3);
            reset_models();
        end else begin
            if (rd_en) begin
                chk("rd_en_in_pass", m_active, 1);
                chk("rd_en_credit", (m_cred > 0) ? 1 : 0, 1);
                chk("rd_idx", rd_idx, m_issued);
                if (m_issued < 64) iss_cyc[m_issued] = cyc;
                m_issued++;
            end
            chk("core_in_val", core_in_val, rdq[RD_LAT-1]);
            if (core_in_val && first_in_cyc < 0) first_in_cyc = cyc;
            if (busy) begin
                chk("busy_in_pass", m_active, 1);
                chk("core_margin", core_margin, m_mar_in);
                chk("core_exp", core_exp, m_exp_in);
            end
            if (done) begin
                chk("done_in_pass", m_active, 1);
                chk("done_busy", busy, 0);
                chk("done_issued", m_issued, m_n);
                chk("done_outputs", m_outs, m_n);
                chk("exp_out", exp_out, (m_n == 0) ? m_exp_in : m_last_exp);
                chk("margin_out", margin_out, (m_n == 0) ? m_mar_in : m_min);
                m_active = 0;
                done_cnt++;
                last_done_issued = m_issued;
            end

            // downstream credit model
            if (rd_en && !cred_ret) m_cred--;
            else if (!rd_en && cred_ret && m_cred < CREDITS) m_cred++;

            for (int i = RD_LAT-1; i > 0; i--) rdq[i] = rdq[i-1];
            rdq[0] = rd_en;

            // core model: fixed-latency pipe with a per-output sample pattern
            for (int i = CORE_LAT; i > 0; i--) ih[i] = ih[i-1];
            ih[0] = core_in_val;
            core_out_val = ih[CORE_LAT];
            if (core_out_val) begin
                for (int i = 0; i < 5; i++) begin
                    re[i] = 18'h00FFF;
                    im[i] = 18'h3F001;
                end
                if (m_outs == spec_idx) re[3] = spec_val;
                for (int i = 0; i < 5; i++) begin
                    if (hr_bits(re[i]) < m_min) m_min = hr_bits(re[i]);
                    if (hr_bits(im[i]) < m_min) m_min = hr_bits(im[i]);
                end
                core_dout_real = re;
                core_dout_imag = im;
                core_exp_out = cur_exp;
                m_last_exp = cur_exp;
                m_outs++;
            end

            if (ret_mode == 0) cred_ret = core_out_val;
            else cred_ret = (cyc >= ret_from);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_pass(input int n, input int e, input int m);
        start = 1'b1;
        n_bfly = IDX_W'(n);
        exp_in = 4'(e);
        margin_in = 2'(m);
        if (!m_active) begin
            m_active = 1; m_n = n; m_exp_in = e; m_mar_in = m;
            m_issued = 0; m_outs = 0; m_min = 3; first_in_cyc = -1;
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        chk("done_seen", done_cnt, d0 + 1);
    endtask

    initial begin
        int d0;
        reset_models();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("rst_credits", int'(u_dut.cred_q), CREDITS);

        // basic pass: four back-to-back issues, quiet samples
        cur_exp = 4'd4; spec_idx = -1;
        d0 = done_cnt;
        start_pass(4, 2, 1);
        wait_done(d0, 60);
        chk("t1_consecutive", iss_cyc[3] - iss_cyc[0], 3);
        chk("t1_in_val_lat", first_in_cyc - iss_cyc[0], 2);
        chk("t1_exp_out", exp_out, 4);
        chk("t1_margin_out", margin_out, 3);

        // credit stall: returns withheld for ten cycles, then one per cycle
        idle(3);
        ret_mode = 1; ret_from = cyc + 10; cur_exp = 4'd6;
        d0 = done_cnt;
        start_pass(12, 3, 2);
        while (cyc < ret_from) step();
        chk("t2_stall_issues", m_issued, 4);
        wait_done(d0, 200);
        chk("t2_resume_delay", iss_cyc[4] - ret_from, 2);
        chk("t2_resume_rate", iss_cyc[11] - iss_cyc[4], 7);
        ret_mode = 0;
        idle(3);

        // margin measurement
        cur_exp = 4'd5; spec_idx = 1; spec_val = 18'h1FFFF;
        d0 = done_cnt;
        start_pass(3, 1, 3);
        wait_done(d0, 60);
        chk("t3_margin0", margin_out, 0);
        idle(3);
        cur_exp = 4'd9; spec_val = 18'h0FFFF;
        d0 = done_cnt;
        start_pass(3, 2, 0);
        wait_done(d0, 60);
        chk("t3_margin1", margin_out, 1);
        chk("t3_exp_out", exp_out, 9);
        spec_idx = -1;
        idle(3);

        // empty pass
        d0 = done_cnt;
        start_pass(0, 7, 2);
        chk("t4_done_next", done, 1);
        chk("t4_exp_out", exp_out, 7);
        chk("t4_margin_out", margin_out, 2);
        idle(4);
        chk("t4_no_issue", m_issued, 0);
        chk("t4_exp_held", exp_out, 7);

        // start while busy is ignored
        cur_exp = 4'd3;
        d0 = done_cnt;
        start_pass(6, 4, 1);
        idle(2);
        start_pass(2, 1, 3);
        wait_done(d0, 80);
        chk("t5_issued", last_done_issued, 6);
        idle(3);

        // reset in the middle of issue
        start_pass(10, 3, 1);
        idle(3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_credits", int'(u_dut.cred_q), CREDITS);
        idle(8);
        chk("t6_no_issue", m_issued, 0);
        chk("t6_busy", busy, 0);
        cur_exp = 4'd11;
        d0 = done_cnt;
        start_pass(3, 8, 2);
        wait_done(d0, 60);
        chk("t6_exp_out", exp_out, 11);
        chk("t6_margin_out", margin_out, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
